// File: rtl/demux_pkg.sv
// Shared constants for the virtual-channel demux: FSM encoding, VC indices,
// and statistics counter width.
package demux_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic VC0 = 1'b0;
   localparam logic VC1 = 1'b1;

   localparam int unsigned STAT_W = 8;

endpackage

// File: rtl/vc_demux_if.sv
// Bus between the main FIFO, the demux, and the two VC FIFOs.
// The slave modport is the demux side; master is the surrounding FIFO side.
interface vc_demux_if #(
   parameter int unsigned DATA_SIZE = 6
);

   logic                 fifo_empty_main;
   logic [DATA_SIZE-1:0] data_demux_vc;
   logic                 pause_vc0;
   logic                 pause_vc1;
   logic                 pop_main;
   logic                 push_vc0;
   logic                 push_vc1;
   logic [DATA_SIZE-1:0] data_vc;
   logic                 demux_idle;

   modport slave (
      input  fifo_empty_main, data_demux_vc, pause_vc0, pause_vc1,
      output pop_main, push_vc0, push_vc1, data_vc, demux_idle
   );

   modport master (
      output fifo_empty_main, data_demux_vc, pause_vc0, pause_vc1,
      input  pop_main, push_vc0, push_vc1, data_vc, demux_idle
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for demux statistics.
module sat_counter #(
   parameter int unsigned STAT_W = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              inc,
   output logic [STAT_W-1:0] cnt
);

   logic [STAT_W-1:0] cnt_q;

   // Clear wins over increment; holds at all-ones once saturated.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {STAT_W{1'b1}})) begin
         cnt_q <= cnt_q + STAT_W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vc_demux.sv
// Routes main-FIFO words to VC0/VC1 by MSB, holding a word while its VC pauses.
// Optional statistics counters are enabled with the DEMUX_STATS_EN macro.
module vc_demux
   import demux_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 6
) (
   input  logic              clk,
   input  logic              reset,
   vc_demux_if.slave         bus
`ifdef DEMUX_STATS_EN
   ,
   output logic [STAT_W-1:0] cnt_vc0,
   output logic [STAT_W-1:0] cnt_vc1,
   output logic [STAT_W-1:0] cnt_stall
`endif
);

   localparam int unsigned MSB = DATA_SIZE - 1;

   logic [1:0]           state_q, state_d;
   logic [DATA_SIZE-1:0] hold_q, hold_d;

   logic                 can_pop;
   logic [DATA_SIZE-1:0] word;
   logic                 dest_paused;
   logic                 pop_c;
   logic                 push0_c;
   logic                 push1_c;
   logic [DATA_SIZE-1:0] data_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next state and strobes; FETCH and HOLD differ only in the word source.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      pop_c       = 1'b0;
      push0_c     = 1'b0;
      push1_c     = 1'b0;
      data_c      = '0;
      word        = '0;
      dest_paused = 1'b0;
      can_pop     = !bus.fifo_empty_main && !(bus.pause_vc0 && bus.pause_vc1);

      case (state_q)
         ST_IDLE: begin
            pop_c = can_pop;
            if (can_pop) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH, ST_HOLD: begin
            word        = (state_q == ST_HOLD) ? hold_q : bus.data_demux_vc;
            dest_paused = (word[MSB] == VC1) ? bus.pause_vc1 : bus.pause_vc0;
            if (!dest_paused) begin
               push0_c = (word[MSB] == VC0);
               push1_c = (word[MSB] == VC1);
               data_c  = word;
               pop_c   = can_pop;
               state_d = can_pop ? ST_FETCH : ST_IDLE;
            end else begin
               hold_d  = word;
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset cycle: whatever is in flight is dropped without a push or pop.
      if (reset) begin
         pop_c   = 1'b0;
         push0_c = 1'b0;
         push1_c = 1'b0;
         data_c  = '0;
      end
   end

   assign bus.pop_main   = pop_c;
   assign bus.push_vc0   = push0_c;
   assign bus.push_vc1   = push1_c;
   assign bus.data_vc    = data_c;
   assign bus.demux_idle = reset || (state_q == ST_IDLE);

`ifdef DEMUX_STATS_EN
   logic stall_inc;

   assign stall_inc = (state_q == ST_HOLD) && !reset;

   sat_counter #(.STAT_W(STAT_W)) u_cnt_vc0 (
      .clk   (clk),
      .clear (reset),
      .inc   (push0_c),
      .cnt   (cnt_vc0)
   );

   sat_counter #(.STAT_W(STAT_W)) u_cnt_vc1 (
      .clk   (clk),
      .clear (reset),
      .inc   (push1_c),
      .cnt   (cnt_vc1)
   );

   sat_counter #(.STAT_W(STAT_W)) u_cnt_stall (
      .clk   (clk),
      .clear (reset),
      .inc   (stall_inc),
      .cnt   (cnt_stall)
   );
`endif

endmodule

// File: tb/tb_vc_demux.sv
// Directed, table-driven bench for vc_demux: one record per clock cycle.
// Counter checks are active when DEMUX_STATS_EN is defined.
module tb_vc_demux;

   localparam int unsigned DW = 6;

   typedef struct {
      logic          rst;
      logic          empty;
      logic [DW-1:0] din;
      logic          p0;
      logic          p1;
      logic          e_pop;
      logic          e_push0;
      logic          e_push1;
      logic [DW-1:0] e_dout;
      logic          e_idle;
   } vec_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   vec_t tbl[$];

   vc_demux_if #(.DATA_SIZE(DW)) bus ();

`ifdef DEMUX_STATS_EN
   logic [7:0] cnt_vc0, cnt_vc1, cnt_stall;
`endif

   vc_demux #(.DATA_SIZE(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DEMUX_STATS_EN
      ,
      .cnt_vc0   (cnt_vc0),
      .cnt_vc1   (cnt_vc1),
      .cnt_stall (cnt_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic empty, input logic [DW-1:0] din,
                               input logic p0, input logic p1, input logic e_pop,
                               input logic e_push0, input logic e_push1,
                               input logic [DW-1:0] e_dout, input logic e_idle);
      vec_t v;
      v.rst = rst; v.empty = empty; v.din = din; v.p0 = p0; v.p1 = p1;
      v.e_pop = e_pop; v.e_push0 = e_push0; v.e_push1 = e_push1;
      v.e_dout = e_dout; v.e_idle = e_idle;
      return v;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then cross the edge.
   task automatic apply(input vec_t v, input string tag);
      reset               = v.rst;
      bus.fifo_empty_main = v.empty;
      bus.data_demux_vc   = v.din;
      bus.pause_vc0       = v.p0;
      bus.pause_vc1       = v.p1;
      @(negedge clk);
      check({tag, ".pop"},   int'(bus.pop_main),   int'(v.e_pop));
      check({tag, ".push0"}, int'(bus.push_vc0),   int'(v.e_push0));
      check({tag, ".push1"}, int'(bus.push_vc1),   int'(v.e_push1));
      check({tag, ".data"},  int'(bus.data_vc),    int'(v.e_dout));
      check({tag, ".idle"},  int'(bus.demux_idle), int'(v.e_idle));
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag, input int c0, input int c1, input int cs);
`ifdef DEMUX_STATS_EN
      check({tag, ".cnt_vc0"},   int'(cnt_vc0),   c0);
      check({tag, ".cnt_vc1"},   int'(cnt_vc1),   c1);
      check({tag, ".cnt_stall"}, int'(cnt_stall), cs);
`else
      if (tag.len() < 0) $display("%0d %0d %0d", c0, c1, cs);
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.fifo_empty_main = 1'b1;
      bus.data_demux_vc   = '0;
      bus.pause_vc0       = 1'b0;
      bus.pause_vc1       = 1'b0;
      @(posedge clk);
      #1;

      // rst empty din   p0 p1 | pop push0 push1 dout  idle
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1));
      // stream 05, 25, 0A, 3F: four back-to-back pops, pushes one cycle later
      tbl.push_back(mk(0, 0, 6'h00, 0, 0, 1, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 0, 6'h05, 0, 0, 1, 1, 0, 6'h05, 0));
      tbl.push_back(mk(0, 0, 6'h25, 0, 0, 1, 0, 1, 6'h25, 0));
      tbl.push_back(mk(0, 0, 6'h0A, 0, 0, 1, 1, 0, 6'h0A, 0));
      tbl.push_back(mk(0, 1, 6'h3F, 0, 0, 0, 0, 1, 6'h3F, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1));
      // 0x21 held by pause_vc1 for 4 cycles, FIFO non-empty meanwhile
      tbl.push_back(mk(0, 0, 6'h00, 0, 0, 1, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 1, 6'h21, 0, 1, 0, 0, 0, 6'h00, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 6'h00, 0, 1, 0, 0, 0, 6'h00, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 0, 0, 0, 1, 6'h21, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1));
      // held VC1 word 0x30 while pause_vc0 toggles
      tbl.push_back(mk(0, 0, 6'h00, 0, 0, 1, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 1, 6'h30, 1, 1, 0, 0, 0, 6'h00, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 1, 0, 0, 0, 6'h00, 0));
      tbl.push_back(mk(0, 1, 6'h00, 1, 0, 0, 0, 1, 6'h30, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1));
      // both pauses high blocks pops; pop resumes when pause_vc0 drops
      tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 0, 6'h00, 1, 1, 0, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 0, 6'h00, 0, 1, 1, 0, 0, 6'h00, 1));
      tbl.push_back(mk(0, 1, 6'h01, 0, 1, 0, 1, 0, 6'h01, 0));
      tbl.push_back(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
      check_stats("table_end", 3, 4, 6);

      // Reset while holding 0x2A: word is discarded, next word routes normally.
      apply(mk(0, 0, 6'h00, 0, 1, 1, 0, 0, 6'h00, 1), "rh_pop");
      apply(mk(0, 1, 6'h2A, 0, 1, 0, 0, 0, 6'h00, 0), "rh_fetch");
      apply(mk(1, 0, 6'h00, 0, 1, 0, 0, 0, 6'h00, 1), "rh_reset");
      apply(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1), "rh_after");
      apply(mk(0, 0, 6'h00, 0, 0, 1, 0, 0, 6'h00, 1), "rh_pop2");
      apply(mk(0, 1, 6'h12, 0, 0, 0, 1, 0, 6'h12, 0), "rh_push");
      apply(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1), "rh_idle");
      check_stats("after_reset", 1, 0, 0);

      // Isolated 0x21 stall after counters were cleared.
      apply(mk(0, 0, 6'h00, 0, 0, 1, 0, 0, 6'h00, 1), "st_pop");
      apply(mk(0, 1, 6'h21, 0, 1, 0, 0, 0, 6'h00, 0), "st_fetch");
      for (int i = 0; i < 3; i++) apply(mk(0, 1, 6'h00, 0, 1, 0, 0, 0, 6'h00, 0), "st_hold");
      apply(mk(0, 1, 6'h00, 0, 0, 0, 0, 1, 6'h21, 0), "st_push");
      apply(mk(0, 1, 6'h00, 0, 0, 0, 0, 0, 6'h00, 1), "st_idle");
      check_stats("stall", 1, 1, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
